alu_share_ctrl: RTL and testbench

// Sequences and shares the single ALU between two requesters (port 0: main datapath, port 1: address/branch unit).

---
 rtl/alu_pkg.sv | 37 +++
 rtl/rr_arb2.sv | 24 ++
 rtl/alu_share_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing controller: ALU op codes, funct codes,
// controller FSM states and the legal-funct check.
package alu_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FN    = 2'b10,
        ALUOP_FN_X  = 2'b11
    } aluop_t;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_MUL = 6'h18;
    localparam logic [5:0] FUNCT_DIV = 6'h1A;
    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_XOR = 6'h26;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic funct_legal(input logic [5:0] funct);
        case (funct)
            FUNCT_ADD, FUNCT_SUB, FUNCT_MUL, FUNCT_DIV, FUNCT_SLL,
            FUNCT_SRL, FUNCT_OR,  FUNCT_AND, FUNCT_NOR, FUNCT_XOR: funct_legal = 1'b1;
            default:                                               funct_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: when both requesters are valid the one named by
// prio wins; grant is only raised while accept is high.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       prio,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       id
);

    always_comb begin
        id    = 1'b0;
        grant = 2'b00;
        if (valid == 2'b11) begin
            id = prio;
        end else begin
            id = valid[1];
        end
        if (accept && (valid != 2'b00)) begin
            grant = id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external ALU between two requesters: arbitrates, captures the op,
// drives the ALU and returns a registered result. Optional macro: MULDIV_STALL_EN.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int W          = 32,
    parameter int MULDIV_LAT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [4:0]   req0_shamt,
    input  logic [5:0]   req0_funct,
    input  logic [1:0]   req0_aluop,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [4:0]   req1_shamt,
    input  logic [5:0]   req1_funct,
    input  logic [1:0]   req1_aluop,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [W-1:0] resp_out,
    output logic         resp_zero,
    output logic         resp_err,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [4:0]   alu_shamt,
    output logic [5:0]   alu_funct,
    output logic [1:0]   alu_aluop,
    input  logic [W-1:0] alu_out,
    input  logic         alu_zero
);

    state_t         state_q, state_d;
    logic           prio_q, prio_d;
    logic [W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [4:0]     op_shamt_q, op_shamt_d;
    logic [5:0]     op_funct_q, op_funct_d;
    logic [1:0]     op_aluop_q, op_aluop_d;
    logic           op_id_q, op_id_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [W-1:0]   resp_out_q, resp_out_d;
    logic           resp_zero_q, resp_zero_d;
    logic           resp_err_q, resp_err_d;

    logic [1:0]     grant;
    logic           grant_id;
    logic [W-1:0]   sel_a, sel_b;
    logic [4:0]     sel_shamt;
    logic [5:0]     sel_funct;
    logic [1:0]     sel_aluop;
    logic           sel_stall;
    logic           op_err;

    rr_arb2 u_arb (
        .valid  ({req1_valid, req0_valid}),
        .prio   (prio_q),
        .accept (state_q == ST_IDLE),
        .grant  (grant),
        .id     (grant_id)
    );

    assign sel_a     = grant_id ? req1_a     : req0_a;
    assign sel_b     = grant_id ? req1_b     : req0_b;
    assign sel_shamt = grant_id ? req1_shamt : req0_shamt;
    assign sel_funct = grant_id ? req1_funct : req0_funct;
    assign sel_aluop = grant_id ? req1_aluop : req0_aluop;

`ifdef MULDIV_STALL_EN
    assign sel_stall = sel_aluop[1] && ((sel_funct == FUNCT_MUL) || (sel_funct == FUNCT_DIV));
`else
    assign sel_stall = 1'b0;
`endif

    // Errors come from the captured op so a late alu_out can never leak through.
    assign op_err = op_aluop_q[1] &&
                    (!funct_legal(op_funct_q) || ((op_funct_q == FUNCT_DIV) && (op_b_q == '0)));

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign resp_valid = (state_q == ST_RESP);
    assign resp_id    = op_id_q;
    assign resp_out   = resp_out_q;
    assign resp_zero  = resp_zero_q;
    assign resp_err   = resp_err_q;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_shamt_d  = op_shamt_q;
        op_funct_d  = op_funct_q;
        op_aluop_d  = op_aluop_q;
        op_id_d     = op_id_q;
        cnt_d       = cnt_q;
        resp_out_d  = resp_out_q;
        resp_zero_d = resp_zero_q;
        resp_err_d  = resp_err_q;
        alu_a       = '0;
        alu_b       = '0;
        alu_shamt   = '0;
        alu_funct   = '0;
        alu_aluop   = ALUOP_ADD;
        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    op_a_d     = sel_a;
                    op_b_d     = sel_b;
                    op_shamt_d = sel_shamt;
                    op_funct_d = sel_funct;
                    op_aluop_d = sel_aluop;
                    op_id_d    = grant_id;
                    prio_d     = ~grant_id;
                    cnt_d      = sel_stall ? 4'(MULDIV_LAT - 1) : 4'd0;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_a     = op_a_q;
                alu_b     = op_b_q;
                alu_shamt = op_shamt_q;
                alu_funct = op_funct_q;
                alu_aluop = op_aluop_q;
                if (cnt_q == 4'd0) begin
                    if (op_err) begin
                        resp_out_d  = '0;
                        resp_zero_d = 1'b1;
                        resp_err_d  = 1'b1;
                    end else begin
                        resp_out_d  = alu_out;
                        resp_zero_d = alu_zero;
                        resp_err_d  = 1'b0;
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_shamt_q  <= '0;
            op_funct_q  <= '0;
            op_aluop_q  <= '0;
            op_id_q     <= 1'b0;
            cnt_q       <= '0;
            resp_out_q  <= '0;
            resp_zero_q <= 1'b0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_shamt_q  <= op_shamt_d;
            op_funct_q  <= op_funct_d;
            op_aluop_q  <= op_aluop_d;
            op_id_q     <= op_id_d;
            cnt_q       <= cnt_d;
            resp_out_q  <= resp_out_d;
            resp_zero_q <= resp_zero_d;
            resp_err_q  <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: behavioural ALU, per-port op queues
// and a result/arbitration model built from the op rules.
module tb_alu_share_ctrl;

    localparam int W          = 32;
    localparam int MULDIV_LAT = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [1:0]  aluop;
    } op_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]   req0_shamt, req1_shamt;
    logic [5:0]   req0_funct, req1_funct;
    logic [1:0]   req0_aluop, req1_aluop;
    logic         resp_valid, resp_ready, resp_id, resp_zero, resp_err;
    logic [W-1:0] resp_out;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic [4:0]   alu_shamt;
    logic [5:0]   alu_funct;
    logic [1:0]   alu_aluop;
    logic         alu_zero;

    int  total = 0;
    int  bad   = 0;
    op_t q0[$];
    op_t q1[$];
    logic prio_m = 1'b0;
    logic [5:0] functs [12] = '{6'h20, 6'h22, 6'h18, 6'h1A, 6'h00, 6'h02,
                                6'h25, 6'h24, 6'h27, 6'h26, 6'h3F, 6'h05};

    alu_share_ctrl #(.W(W), .MULDIV_LAT(MULDIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_shamt(req0_shamt), .req0_funct(req0_funct), .req0_aluop(req0_aluop),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_shamt(req1_shamt), .req1_funct(req1_funct), .req1_aluop(req1_aluop),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_out(resp_out), .resp_zero(resp_zero), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_funct(alu_funct),
        .alu_aluop(alu_aluop), .alu_out(alu_out), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    // External ALU stand-in; undefined and divide-by-zero cases return junk on purpose.
    always_comb begin
        alu_out = '0;
        case (alu_aluop)
            2'b00:   alu_out = alu_a + alu_b;
            2'b01:   alu_out = alu_a - alu_b;
            default: begin
                case (alu_funct)
                    6'h20:   alu_out = alu_a + alu_b;
                    6'h22:   alu_out = alu_a - alu_b;
                    6'h18:   alu_out = alu_a * alu_b;
                    6'h1A:   alu_out = (alu_b == '0) ? 32'hFFFF_FFFF : alu_a / alu_b;
                    6'h00:   alu_out = alu_b << alu_shamt;
                    6'h02:   alu_out = alu_b >> alu_shamt;
                    6'h25:   alu_out = alu_a | alu_b;
                    6'h24:   alu_out = alu_a & alu_b;
                    6'h27:   alu_out = ~(alu_a | alu_b);
                    6'h26:   alu_out = alu_a ^ alu_b;
                    default: alu_out = 32'hDEAD_BEEF;
                endcase
            end
        endcase
        alu_zero = (alu_out == '0);
    end

    // Returns {err, result} for one op.
    function automatic logic [32:0] model_result(input op_t o);
        logic [31:0] r;
        logic        e;
        r = 32'd0;
        e = 1'b0;
        if (o.aluop == 2'b00) begin
            r = o.a + o.b;
        end else if (o.aluop == 2'b01) begin
            r = o.a - o.b;
        end else begin
            case (o.funct)
                6'h20: r = o.a + o.b;
                6'h22: r = o.a - o.b;
                6'h18: r = o.a * o.b;
                6'h1A: if (o.b == 32'd0) e = 1'b1; else r = o.a / o.b;
                6'h00: r = o.b << o.shamt;
                6'h02: r = o.b >> o.shamt;
                6'h25: r = o.a | o.b;
                6'h24: r = o.a & o.b;
                6'h27: r = ~(o.a | o.b);
                6'h26: r = o.a ^ o.b;
                default: e = 1'b1;
            endcase
        end
        return {e, r};
    endfunction

    // Cycles from the handshake edge to the first negedge showing resp_valid.
    function automatic int exp_lat(input op_t o);
`ifdef MULDIV_STALL_EN
        if (o.aluop[1] && (o.funct == 6'h18 || o.funct == 6'h1A)) return 1 + MULDIV_LAT;
`endif
        return 2;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.a     = $urandom;
        o.b     = $urandom;
        o.shamt = 5'($urandom);
        o.aluop = 2'($urandom);
        o.funct = functs[$urandom_range(0, 11)];
        if ($urandom_range(0, 3) == 0) o.b = (o.funct == 6'h1A) ? 32'd0 : o.a;
        return o;
    endfunction

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b,
                               input logic [5:0] funct, input logic [1:0] aluop);
        op_t o;
        o.a = a; o.b = b; o.shamt = 5'd0; o.funct = funct; o.aluop = aluop;
        return o;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ports();
        if (q0.size() > 0) begin
            req0_valid = 1'b1; req0_a = q0[0].a; req0_b = q0[0].b;
            req0_shamt = q0[0].shamt; req0_funct = q0[0].funct; req0_aluop = q0[0].aluop;
        end else begin
            req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom;
            req0_shamt = 5'($urandom); req0_funct = 6'($urandom); req0_aluop = 2'($urandom);
        end
        if (q1.size() > 0) begin
            req1_valid = 1'b1; req1_a = q1[0].a; req1_b = q1[0].b;
            req1_shamt = q1[0].shamt; req1_funct = q1[0].funct; req1_aluop = q1[0].aluop;
        end else begin
            req1_valid = 1'b0; req1_a = $urandom; req1_b = $urandom;
            req1_shamt = 5'($urandom); req1_funct = 6'($urandom); req1_aluop = 2'($urandom);
        end
    endtask

    // One transaction from the queue heads; entered and left at a negedge with the DUT idle.
    task automatic applyStimulus(input int hold);
        op_t          op;
        logic         id;
        int           lat;
        logic [32:0]  er;
        drive_ports();
        #1;
        if (q0.size() > 0 && q1.size() > 0) id = prio_m;
        else                                id = (q1.size() > 0);
        checkOutput("grant", {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
        op = id ? q1.pop_front() : q0.pop_front();
        prio_m = ~id;
        er = model_result(op);
        resp_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        drive_ports();
        #1;
        checkOutput("exec_alu_a", alu_a, op.a);
        checkOutput("exec_alu_b", alu_b, op.b);
        checkOutput("exec_alu_ctl", {alu_shamt, alu_funct, alu_aluop}, {op.shamt, op.funct, op.aluop});
        checkOutput("exec_ready", {req1_ready, req0_ready}, 2'b00);
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", lat, exp_lat(op));
        checkOutput("resp_out", resp_out, er[31:0]);
        checkOutput("resp_flags", {resp_id, resp_zero, resp_err}, {id, er[31:0] == 32'd0, er[32]});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_ctl", {resp_valid, resp_id, resp_zero, resp_err, req1_ready, req0_ready},
                        {1'b1, id, er[31:0] == 32'd0, er[32], 2'b00});
            checkOutput("hold_out", resp_out, er[31:0]);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checkOutput("resp_drop", resp_valid, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        resp_ready = 1'b1;
        drive_ports();
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", {req1_ready, req0_ready}, 2'b00);
        checkOutput("rst_resp", {resp_valid, resp_id, resp_zero, resp_err}, 4'b0000);
        checkOutput("rst_out", resp_out, 32'd0);
        checkOutput("rst_alu_ab", {alu_a, alu_b}, 64'd0);
        checkOutput("rst_alu_ctl", {alu_shamt, alu_funct, alu_aluop}, 13'd0);
        rst_n = 1'b1;

        // Both ports loaded from reset: grants must alternate 0,1,0,1.
        for (int i = 0; i < 2; i++) begin
            q0.push_back(mk($urandom, $urandom, 6'h20, 2'b00));
            q1.push_back(mk($urandom, $urandom, 6'h22, 2'b01));
        end
        while (q0.size() + q1.size() > 0) applyStimulus(0);

        q0.push_back(mk(32'd5, 32'd7, 6'h00, 2'b00));
        applyStimulus(0);
        q1.push_back(mk(32'd9, 32'd0, 6'h1A, 2'b10));
        applyStimulus(0);
        q0.push_back(mk(32'd9, 32'd4, 6'h3F, 2'b10));
        applyStimulus(0);
        q1.push_back(mk(32'd3, 32'd3, 6'h00, 2'b01));
        applyStimulus(0);
        q0.push_back(mk(32'd6, 32'd7, 6'h18, 2'b10));
        applyStimulus(0);
        q1.push_back(mk(32'd100, 32'd7, 6'h1A, 2'b11));
        applyStimulus(0);

        // Consumer stalls 5 cycles with the other port waiting.
        q0.push_back(mk(32'h0F0F, 32'h00FF, 6'h26, 2'b10));
        q1.push_back(mk(32'h1234, 32'h0001, 6'h25, 2'b10));
        applyStimulus(5);
        applyStimulus(0);

        // Reset while an op from port 0 is executing.
        q0.push_back(mk(32'd1, 32'd2, 6'h00, 2'b00));
        drive_ports();
        #1;
        checkOutput("pre_rst_grant", {req1_ready, req0_ready}, 2'b01);
        void'(q0.pop_front());
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        drive_ports();
        repeat (3) begin
            @(negedge clk);
            checkOutput("mid_rst_resp", {resp_valid, req1_ready, req0_ready}, 3'b000);
        end
        rst_n  = 1'b1;
        prio_m = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("post_rst_idle", resp_valid, 1'b0);
        end
        q0.push_back(mk(32'd11, 32'd22, 6'h00, 2'b00));
        q1.push_back(mk(32'd33, 32'd44, 6'h00, 2'b00));
        applyStimulus(0);
        applyStimulus(1);

        // Randomised traffic across both ports.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) q0.push_back(rand_op());
            else                           q1.push_back(rand_op());
        end
        while (q0.size() + q1.size() > 0) applyStimulus($urandom_range(0, 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
